ederah_result_packer: RTL and testbench
=======================================

# ederah_result_packer

Downstream stage of the ERBIUM/EDERAH engine wrapper. It collects the narrow per-match result identifiers emitted by the NFA core and packs them, lane by lane, into full-width host-stream beats. It generates `wr_keep_o` for partial beats and forwards end-of-query as `wr_last_o`, so the results stream towards the host carries valid `tkeep`/`tlast` instead of leaving them undriven.

## Interface
- `G_DATA_BUS_WIDTH`, 512: output beat width in bits.
- `G_RESULT_WIDTH`, 16: result word width in bits.
  - Must be a multiple of 8.
  - Must divide `G_DATA_BUS_WIDTH`.
  - LANES = `G_DATA_BUS_WIDTH`/`G_RESULT_WIDTH` (≥2).
- `clk_i` in 1: single clock (kernel clock domain).
- `rst_i` in 1: reset, asynchronous, active-high.
- `res_data_i` in `G_RESULT_WIDTH`: result word from core.
- `res_valid_i` in 1: result word valid.
- `res_last_i` in 1: this word is the final result of the current query.
- `res_ready_o` out 1: packer accepts the result word.
- `wr_data_o` out `G_DATA_BUS_WIDTH`: packed beat.
- `wr_keep_o` out `G_DATA_BUS_WIDTH`/8: byte enables of the packed beat.
- `wr_valid_o` out 1: beat valid.
- `wr_last_o` out 1: last beat of the query.
- `wr_ready_i` in 1: downstream accepts the beat.
- `stat_results_o` out 32: results accepted. Present only with the macro.
- `stat_beats_o` out 32: beats emitted. Present only with the macro.
- `stat_queries_o` out 32: last-beats emitted. Present only with the macro.

## Operation
- **Transfer definitions:**
  - Input accept: `res_valid_i & res_ready_o`.
  - Output transfer: `wr_valid_o & wr_ready_i`.
- **Internal state:**
  - Accumulator `acc` (`G_DATA_BUS_WIDTH`), cleared to 0.
  - Lane index `idx` (0..LANES-1), 0 after reset.
  - Single-entry output register.
- **On each input accept:**
  - Write `res_data_i` into lane `idx`, bits [`idx`*W +: W]. Lane 0 is least significant.
  - **Beat completes** when `idx`==LANES-1 or `res_last_i`=1:
    - Load `acc` (including the current word) into the output register.
    - `wr_keep_o` = ones for bytes [0 .. (`idx`+1)*W/8-1], zeros above.
    - `wr_last_o` = `res_last_i`.
    - Clear `acc` and set `idx` to 0.
  - **Otherwise:** `idx` increments by 1.
- Unwritten lanes of a partial beat are 0 in `wr_data_o`.
- `res_ready_o` = ~`rst_i` & (~`wr_valid_o` | `wr_ready_i`).
  - This is a combinational path from `wr_ready_i`.
  - Input is stalled whenever a held beat is not draining, including accepts that would not complete a beat.
- **Output register:**
  - Set `wr_valid_o` on beat completion.
  - Clear `wr_valid_o` on an output transfer with no simultaneous completion.
  - Simultaneous transfer and completion: the new beat replaces the old one, and `wr_valid_o` stays 1.
- While `wr_valid_o`=1 and `wr_ready_i`=0, `wr_data_o`/`wr_keep_o`/`wr_last_o` are held stable.
- A query with zero results produces no beat. The core must emit at least one result word carrying `res_last_i` per query.
- Reset is asynchronous and immediate:
  - `acc`, `idx` and the output register are cleared.
  - A partially packed beat is discarded.
  - After deassertion, the next word lands in lane 0.

## Timing
- **Reset values:**
  - `wr_valid_o`=0, `wr_last_o`=0.
  - `wr_keep_o`=0, `wr_data_o`=0.
  - `res_ready_o`=0 while `rst_i`=1.
  - Stat counters = 0.
- **Latency:** a completing accept at edge N gives `wr_valid_o`=1 after edge N (visible in cycle N+1).
- **Throughput:**
  - 1 result word per cycle while downstream is ready.
  - 1 beat per LANES cycles sustained.
  - 1 beat per cycle for back-to-back single-result queries.
- `wr_last_o` is registered together with the beat. No bubbles are inserted between queries.

## Configuration
- **`ERBIUM_RESULT_STATS_EN` defined:**
  - `stat_results_o` increments per input accept.
  - `stat_beats_o` increments per output transfer.
  - `stat_queries_o` increments per output transfer with `wr_last_o`=1.
  - All three counters wrap modulo 2^32 and clear on `rst_i`.
- **Macro not defined:** the three stat ports and counters are absent. Datapath behaviour is identical.

## Test plan
All scenarios use the defaults: W=16, LANES=32, keep width 64.
- **Full beat:** 32 words 0x0001..0x0020, `res_last_i` on the 32nd, `wr_ready_i`=1 → one beat with `wr_keep_o`=all ones, lane0=0x0001, lane31=0x0020, `wr_last_o`=1, `wr_valid_o` one cycle after the last accept.
- **Partial beat:** 3 words 0xA, 0xB, 0xC, last on the third → `wr_keep_o`=0x3F, bits[47:0]=0x000C000B000A, bits above 48 zero, `wr_last_o`=1.
- **Multi-beat query:** 40 words, last on the 40th → beat 1 with keep all ones and `wr_last_o`=0, then beat 2 with keep=0xFFFF and `wr_last_o`=1, data in order.
- **Backpressure:** `wr_ready_i`=0 for 10 cycles while 64 words are offered → `res_ready_o`=0 once beat 1 is held, beat 1 stable throughout, then both beats delivered with no loss or reorder.
- **Reset mid-beat:** 5 words accepted, `rst_i` pulsed → `wr_valid_o`=0 immediately and no beat emitted; the next query's first word appears in lane 0.
- **Stats (macro defined):** two queries of 3 and 40 words → `stat_results_o`=43, `stat_beats_o`=3, `stat_queries_o`=2.

Source files
------------

// File: rtl/ederah_result_packer.sv
// rtl/ederah_result_packer.sv - packs narrow NFA result words into full-width host-stream beats with keep/last
// Optional statistics counters: define ERBIUM_RESULT_STATS_EN to add stat_results_o/stat_beats_o/stat_queries_o.
module ederah_result_packer #(
    parameter int G_DATA_BUS_WIDTH = 512,
    parameter int G_RESULT_WIDTH   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [G_RESULT_WIDTH-1:0]       res_data_i,
    input  logic                            res_valid_i,
    input  logic                            res_last_i,
    output logic                            res_ready_o,
    output logic [G_DATA_BUS_WIDTH-1:0]     wr_data_o,
    output logic [G_DATA_BUS_WIDTH/8-1:0]   wr_keep_o,
    output logic                            wr_valid_o,
    output logic                            wr_last_o,
    input  logic                            wr_ready_i
`ifdef ERBIUM_RESULT_STATS_EN
    ,
    output logic [31:0]                     stat_results_o,
    output logic [31:0]                     stat_beats_o,
    output logic [31:0]                     stat_queries_o
`endif
);

    localparam int LANES  = G_DATA_BUS_WIDTH / G_RESULT_WIDTH;
    localparam int KEEP_W = G_DATA_BUS_WIDTH / 8;
    localparam int BPL    = G_RESULT_WIDTH / 8;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [G_DATA_BUS_WIDTH-1:0] acc;
    logic [G_DATA_BUS_WIDTH-1:0] acc_merged;
    logic [KEEP_W-1:0]           keep_next;
    logic [IDX_W-1:0]            idx;
    logic                        accept;
    logic                        complete;
    logic                        out_xfer;

    // A held beat that is not draining blocks every input word, even ones that would not complete a beat.
    assign res_ready_o = ~rst_i & (~wr_valid_o | wr_ready_i);
    assign accept      = res_valid_i & res_ready_o;
    assign complete    = accept & ((idx == LAST_IDX) | res_last_i);
    assign out_xfer    = wr_valid_o & wr_ready_i;

    // Accumulator with the incoming word dropped into the current lane, and byte enables up to that lane.
    always_comb begin
        acc_merged = acc;
        acc_merged[int'(idx) * G_RESULT_WIDTH +: G_RESULT_WIDTH] = res_data_i;
        keep_next = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l <= int'(idx)) begin
                keep_next[l * BPL +: BPL] = {BPL{1'b1}};
            end
        end
    end

    // Lane accumulation, beat completion into the single output register, and output handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc        <= '0;
            idx        <= '0;
            wr_data_o  <= '0;
            wr_keep_o  <= '0;
            wr_last_o  <= 1'b0;
            wr_valid_o <= 1'b0;
        end else begin
            if (complete) begin
                acc <= '0;
                idx <= '0;
            end else if (accept) begin
                acc <= acc_merged;
                idx <= idx + 1'b1;
            end

            // A completing accept can only happen when the old beat is absent or leaving, so overwrite is safe.
            if (complete) begin
                wr_data_o  <= acc_merged;
                wr_keep_o  <= keep_next;
                wr_last_o  <= res_last_i;
                wr_valid_o <= 1'b1;
            end else if (out_xfer) begin
                wr_valid_o <= 1'b0;
            end
        end
    end

`ifdef ERBIUM_RESULT_STATS_EN
    // Free-running wrap-around counters of accepted words, emitted beats and emitted last-beats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_results_o <= '0;
            stat_beats_o   <= '0;
            stat_queries_o <= '0;
        end else begin
            if (accept) begin
                stat_results_o <= stat_results_o + 32'd1;
            end
            if (out_xfer) begin
                stat_beats_o <= stat_beats_o + 32'd1;
            end
            if (out_xfer & wr_last_o) begin
                stat_queries_o <= stat_queries_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ederah_result_packer.sv
// tb/tb_ederah_result_packer.sv - directed table-driven bench for ederah_result_packer
module tb_ederah_result_packer;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [15:0]   res_data_i;
    logic          res_valid_i;
    logic          res_last_i;
    logic          res_ready_o;
    logic [511:0]  wr_data_o;
    logic [63:0]   wr_keep_o;
    logic          wr_valid_o;
    logic          wr_last_o;
    logic          wr_ready_i;
`ifdef ERBIUM_RESULT_STATS_EN
    logic [31:0]   stat_results_o;
    logic [31:0]   stat_beats_o;
    logic [31:0]   stat_queries_o;
`endif

    ederah_result_packer #(.G_DATA_BUS_WIDTH(512), .G_RESULT_WIDTH(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .res_data_i  (res_data_i),
        .res_valid_i (res_valid_i),
        .res_last_i  (res_last_i),
        .res_ready_o (res_ready_o),
        .wr_data_o   (wr_data_o),
        .wr_keep_o   (wr_keep_o),
        .wr_valid_o  (wr_valid_o),
        .wr_last_o   (wr_last_o),
        .wr_ready_i  (wr_ready_i)
`ifdef ERBIUM_RESULT_STATS_EN
        ,
        .stat_results_o (stat_results_o),
        .stat_beats_o   (stat_beats_o),
        .stat_queries_o (stat_queries_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          n;
        logic [15:0] base;
        int          nbeats;
        logic [63:0] keep0;
        logic        last0;
        logic [63:0] keep1;
        logic        last1;
        logic [47:0] lo0;
    } vec_t;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        int           cyc;
    } beat_t;

    beat_t q[$];
    beat_t mon_bt;
    int    cyc  = 0;
    int    nvec = 0;
    int    nmis = 0;

    always @(posedge clk_i) cyc++;

    // Beats are captured mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && wr_valid_o && wr_ready_i) begin
            mon_bt.data = wr_data_o;
            mon_bt.keep = wr_keep_o;
            mon_bt.last = wr_last_o;
            mon_bt.cyc  = cyc;
            q.push_back(mon_bt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int   g;
        logic ok;
        g  = 0;
        ok = 1'b0;
        res_data_i  = d;
        res_valid_i = 1'b1;
        res_last_i  = l;
        do begin
            @(negedge clk_i);
            ok = res_ready_o;
            @(posedge clk_i);
            #1;
            g++;
        end while (!ok && g < 200);
        if (!ok) chk("send_timeout", 512'(ok), 512'(1'b1));
        res_valid_i = 1'b0;
        res_last_i  = 1'b0;
    endtask

    task automatic send_query(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) send(base + 16'(i), i == n - 1);
    endtask

    task automatic check_beats(input vec_t v);
        beat_t        bt;
        logic [511:0] ed;
        int           k;
        chk("beat_count", 512'(q.size()), 512'(v.nbeats));
        for (int b = 0; b < v.nbeats && q.size() > 0; b++) begin
            bt = q.pop_front();
            ed = '0;
            for (int l = 0; l < 32; l++) begin
                k = b * 32 + l;
                if (k < v.n) ed[l*16 +: 16] = v.base + 16'(k);
            end
            chk("beat_data", bt.data, ed);
            chk("beat_keep", 512'(bt.keep), 512'(b == 0 ? v.keep0 : v.keep1));
            chk("beat_last", 512'(bt.last), 512'(b == 0 ? v.last0 : v.last1));
            if (b == 0) chk("beat_lo48", 512'(bt.data[47:0]), 512'(v.lo0));
        end
        q.delete();
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        q.delete();
    endtask

    vec_t         tbl[6];
    vec_t         bp;
    logic [511:0] snap;
    int           g;

    initial begin
        tbl[0] = '{32, 16'h0001, 1, {64{1'b1}}, 1'b1, 64'h0,       1'b0, 48'h000300020001};
        tbl[1] = '{3,  16'h000A, 1, 64'h3F,     1'b1, 64'h0,       1'b0, 48'h000C000B000A};
        tbl[2] = '{40, 16'h0100, 2, {64{1'b1}}, 1'b0, 64'hFFFF,    1'b1, 48'h010201010100};
        tbl[3] = '{1,  16'h7777, 1, 64'h3,      1'b1, 64'h0,       1'b0, 48'h000000007777};
        tbl[4] = '{33, 16'h0200, 2, {64{1'b1}}, 1'b0, 64'h3,       1'b1, 48'h020202010200};
        tbl[5] = '{64, 16'h0300, 2, {64{1'b1}}, 1'b0, {64{1'b1}}, 1'b1, 48'h030203010300};
        bp     = '{64, 16'h0400, 2, {64{1'b1}}, 1'b0, {64{1'b1}}, 1'b1, 48'h040204010400};

        rst_i       = 1'b1;
        res_data_i  = '0;
        res_valid_i = 1'b0;
        res_last_i  = 1'b0;
        wr_ready_i  = 1'b1;
        idle(2);
        chk("rst_valid", 512'(wr_valid_o), 512'(0));
        chk("rst_last",  512'(wr_last_o),  512'(0));
        chk("rst_keep",  512'(wr_keep_o),  512'(0));
        chk("rst_data",  wr_data_o,        512'(0));
        chk("rst_ready", 512'(res_ready_o), 512'(0));
`ifdef ERBIUM_RESULT_STATS_EN
        chk("rst_stat_results", 512'(stat_results_o), 512'(0));
        chk("rst_stat_beats",   512'(stat_beats_o),   512'(0));
        chk("rst_stat_queries", 512'(stat_queries_o), 512'(0));
`endif
        rst_i = 1'b0;
        idle(1);

        for (int i = 0; i < 6; i++) begin
            q.delete();
            send_query(tbl[i].n, tbl[i].base);
            chk("latency_valid", 512'(wr_valid_o), 512'(1));
            idle(3);
            check_beats(tbl[i]);
        end

        // Back-to-back single-word queries: one beat per cycle, no bubbles.
        send(16'h0011, 1'b1);
        send(16'h0022, 1'b1);
        send(16'h0033, 1'b1);
        idle(3);
        chk("b2b_count", 512'(q.size()), 512'(3));
        if (q.size() == 3) begin
            chk("b2b_d0",  q[0].data, 512'(16'h0011));
            chk("b2b_d1",  q[1].data, 512'(16'h0022));
            chk("b2b_d2",  q[2].data, 512'(16'h0033));
            chk("b2b_gap1", 512'(q[1].cyc - q[0].cyc), 512'(1));
            chk("b2b_gap2", 512'(q[2].cyc - q[1].cyc), 512'(1));
        end
        q.delete();

        // Backpressure: beat 1 held for 10 cycles while 64 words are offered.
        wr_ready_i = 1'b0;
        fork
            send_query(64, 16'h0400);
            begin
                g = 0;
                @(negedge clk_i);
                while (!wr_valid_o && g < 200) begin
                    @(negedge clk_i);
                    g++;
                end
                chk("bp_held", 512'(wr_valid_o), 512'(1));
                snap = wr_data_o;
                repeat (10) begin
                    @(negedge clk_i);
                    chk("bp_ready_low", 512'(res_ready_o), 512'(0));
                    chk("bp_stable_data", wr_data_o, snap);
                    chk("bp_stable_keep", 512'(wr_keep_o), 512'({64{1'b1}}));
                    chk("bp_stable_last", 512'(wr_last_o), 512'(0));
                end
                @(posedge clk_i);
                #1;
                wr_ready_i = 1'b1;
            end
        join
        idle(3);
        check_beats(bp);

        // Reset with a held beat: output cleared asynchronously, mid-cycle.
        wr_ready_i = 1'b0;
        send(16'h0099, 1'b1);
        chk("held_before_rst", 512'(wr_valid_o), 512'(1));
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 512'(wr_valid_o), 512'(0));
        chk("async_rst_ready", 512'(res_ready_o), 512'(0));
        wr_ready_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        q.delete();
        idle(1);

        // Reset mid-beat: partial beat discarded, next word lands in lane 0.
        for (int i = 0; i < 5; i++) send(16'h0500 + 16'(i), 1'b0);
        rst_i = 1'b1;
        #1;
        chk("midbeat_rst_valid", 512'(wr_valid_o), 512'(0));
        idle(2);
        rst_i = 1'b0;
        idle(2);
        chk("midbeat_no_beat", 512'(q.size()), 512'(0));
        send(16'h0055, 1'b1);
        idle(3);
        chk("post_rst_count", 512'(q.size()), 512'(1));
        if (q.size() == 1) begin
            chk("post_rst_lane0", q[0].data, 512'(16'h0055));
            chk("post_rst_keep", 512'(q[0].keep), 512'(64'h3));
            chk("post_rst_last", 512'(q[0].last), 512'(1));
        end
        q.delete();

`ifdef ERBIUM_RESULT_STATS_EN
        pulse_reset();
        idle(1);
        send_query(3, 16'h0A00);
        send_query(40, 16'h0B00);
        idle(3);
        chk("stat_results", 512'(stat_results_o), 512'(43));
        chk("stat_beats",   512'(stat_beats_o),   512'(3));
        chk("stat_queries", 512'(stat_queries_o), 512'(2));
        q.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
